// File: rtl/regfile_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared definitions for the register-file writeback arbiter slice:
//   - register-index and data widths
//   - default exception-pointer / zero register indices and the ALU
//     starvation threshold
//   - requester identifiers used by the arbiter's grant decision
// No ports (package).
// ---------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] XP_REG_DEFAULT       = 5'd30;
    localparam logic [REG_W-1:0] ZERO_REG_DEFAULT     = 5'd31;
    localparam logic [2:0]       STARVE_LIMIT_DEFAULT = 3'd4;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_XP   = 2'd1,
        REQ_LD   = 2'd2,
        REQ_ALU  = 2'd3
    } req_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles every non-clock signal of the writeback arbiter.
//   master modport : requesters / decode / register-file side (drives
//                    valids, data, reservations and source indices)
//   slave modport  : the arbiter itself (drives readies, hazard and the
//                    register-file write port)
// Signals: xp_valid/xp_wd/xp_ready, ld_valid/ld_addr/ld_wd/ld_ready,
//          alu_valid/alu_addr/alu_wd/alu_ready, rsv_en/rsv_addr,
//          chk_a/chk_b/hazard, rf_werf/rf_wasel/rf_wa/rf_wd.
// Optional macro RF_ARB_FWD_EN adds fwd_a_hit, fwd_b_hit, fwd_data.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic              xp_valid;
    logic [DATA_W-1:0] xp_wd;
    logic              xp_ready;

    logic              ld_valid;
    logic [REG_W-1:0]  ld_addr;
    logic [DATA_W-1:0] ld_wd;
    logic              ld_ready;

    logic              alu_valid;
    logic [REG_W-1:0]  alu_addr;
    logic [DATA_W-1:0] alu_wd;
    logic              alu_ready;

    logic              rsv_en;
    logic [REG_W-1:0]  rsv_addr;
    logic [REG_W-1:0]  chk_a;
    logic [REG_W-1:0]  chk_b;
    logic              hazard;

    logic              rf_werf;
    logic              rf_wasel;
    logic [REG_W-1:0]  rf_wa;
    logic [DATA_W-1:0] rf_wd;

`ifdef RF_ARB_FWD_EN
    logic              fwd_a_hit;
    logic              fwd_b_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    modport master (
        output xp_valid, xp_wd, ld_valid, ld_addr, ld_wd,
        output alu_valid, alu_addr, alu_wd, rsv_en, rsv_addr, chk_a, chk_b,
`ifdef RF_ARB_FWD_EN
        input  fwd_a_hit, fwd_b_hit, fwd_data,
`endif
        input  xp_ready, ld_ready, alu_ready, hazard,
        input  rf_werf, rf_wasel, rf_wa, rf_wd
    );

    modport slave (
        input  xp_valid, xp_wd, ld_valid, ld_addr, ld_wd,
        input  alu_valid, alu_addr, alu_wd, rsv_en, rsv_addr, chk_a, chk_b,
`ifdef RF_ARB_FWD_EN
        output fwd_a_hit, fwd_b_hit, fwd_data,
`endif
        output xp_ready, ld_ready, alu_ready, hazard,
        output rf_werf, rf_wasel, rf_wa, rf_wd
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
// 32-entry pending-write vector used by decode to detect RAW hazards.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   set_en_i, set_idx_i decode reserves a destination register
//   clr_en_i, clr_idx_i register-file write retiring a destination
//   chk_a_i, chk_b_i    decode source indices to look up
//   mask_a_i, mask_b_i  suppress a source that is being forwarded
//   hazard_o            a looked-up source still has a pending write
// ---------------------------------------------------------------------------
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter logic [REG_W-1:0] ZERO_REG = ZERO_REG_DEFAULT
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en_i,
    input  logic [REG_W-1:0] set_idx_i,
    input  logic             clr_en_i,
    input  logic [REG_W-1:0] clr_idx_i,
    input  logic [REG_W-1:0] chk_a_i,
    input  logic [REG_W-1:0] chk_b_i,
    input  logic             mask_a_i,
    input  logic             mask_b_i,
    output logic             hazard_o
);

    logic [31:0] pending_q;
    logic [31:0] pending_d;

    // Clear is applied before set so that a reservation landing on the
    // register being written in the same cycle stays pending; the zero
    // register can never be pending because nothing ever writes it.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i && (set_idx_i != ZERO_REG)) begin
            pending_d[set_idx_i] = 1'b1;
        end
        pending_d[ZERO_REG] = 1'b0;
    end

    // Pending vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A forwarded source is already satisfied this cycle, so it is masked.
    assign hazard_o = (pending_q[chk_a_i] & ~mask_a_i) |
                      (pending_q[chk_b_i] & ~mask_b_i);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port between the exception XP
// save, memory load return and ALU result, and tracks outstanding
// destinations for decode hazard detection.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    regfile_wb_arbiter_if.slave (requests, readies, reservations,
//          hazard lookup and register-file write port)
// Priority XP > LD > ALU, except that an ALU request stalled for
// STARVE_LIMIT consecutive cycles is ranked first. A grant produces a
// registered write one cycle later.
// Optional macro RF_ARB_FWD_EN: forwarding of the in-flight write to the
// decode sources (fwd_a_hit, fwd_b_hit, fwd_data).
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter logic [REG_W-1:0] XP_REG       = XP_REG_DEFAULT,
    parameter logic [REG_W-1:0] ZERO_REG     = ZERO_REG_DEFAULT,
    parameter logic [2:0]       STARVE_LIMIT = STARVE_LIMIT_DEFAULT
)(
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    req_e              grant;
    logic [2:0]        starveCnt_q, starveCnt_d;
    logic              rfWerf_q, rfWerf_d;
    logic              rfWasel_q, rfWasel_d;
    logic [REG_W-1:0]  rfWa_q, rfWa_d;
    logic [DATA_W-1:0] rfWd_q, rfWd_d;
    logic [REG_W-1:0]  wrIdx;
    logic              hitA, hitB;

    // Grant selection; readies are forced low while reset is held.
    always_comb begin
        grant = REQ_NONE;
        if (!rst_n) begin
            grant = REQ_NONE;
        end else if (bus.alu_valid && (starveCnt_q == STARVE_LIMIT)) begin
            grant = REQ_ALU;
        end else if (bus.xp_valid) begin
            grant = REQ_XP;
        end else if (bus.ld_valid) begin
            grant = REQ_LD;
        end else if (bus.alu_valid) begin
            grant = REQ_ALU;
        end
    end

    assign bus.xp_ready  = (grant == REQ_XP);
    assign bus.ld_ready  = (grant == REQ_LD);
    assign bus.alu_ready = (grant == REQ_ALU);

    // Next-state for the starvation counter and the write-port register.
    // Address/data only move on a real write so they hold otherwise; a
    // granted write to the zero register is accepted but never issued.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!bus.alu_valid || (grant == REQ_ALU)) begin
            starveCnt_d = '0;
        end else if (starveCnt_q < STARVE_LIMIT) begin
            starveCnt_d = starveCnt_q + 3'd1;
        end

        rfWerf_d  = 1'b0;
        rfWasel_d = rfWasel_q;
        rfWa_d    = rfWa_q;
        rfWd_d    = rfWd_q;
        case (grant)
            REQ_XP: begin
                rfWerf_d  = 1'b1;
                rfWasel_d = 1'b1;
                rfWa_d    = XP_REG;
                rfWd_d    = bus.xp_wd;
            end
            REQ_LD: begin
                if (bus.ld_addr != ZERO_REG) begin
                    rfWerf_d  = 1'b1;
                    rfWasel_d = 1'b0;
                    rfWa_d    = bus.ld_addr;
                    rfWd_d    = bus.ld_wd;
                end
            end
            REQ_ALU: begin
                if (bus.alu_addr != ZERO_REG) begin
                    rfWerf_d  = 1'b1;
                    rfWasel_d = 1'b0;
                    rfWa_d    = bus.alu_addr;
                    rfWd_d    = bus.alu_wd;
                end
            end
            default: begin
            end
        endcase
    end

    // Registered state; reset drops any write that was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starveCnt_q <= '0;
            rfWerf_q    <= 1'b0;
            rfWasel_q   <= 1'b0;
            rfWa_q      <= '0;
            rfWd_q      <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
            rfWerf_q    <= rfWerf_d;
            rfWasel_q   <= rfWasel_d;
            rfWa_q      <= rfWa_d;
            rfWd_q      <= rfWd_d;
        end
    end

    assign bus.rf_werf  = rfWerf_q;
    assign bus.rf_wasel = rfWasel_q;
    assign bus.rf_wa    = rfWa_q;
    assign bus.rf_wd    = rfWd_q;

    // Register actually being written this cycle.
    assign wrIdx = rfWasel_q ? XP_REG : rfWa_q;

`ifdef RF_ARB_FWD_EN
    assign hitA          = rfWerf_q && (wrIdx == bus.chk_a);
    assign hitB          = rfWerf_q && (wrIdx == bus.chk_b);
    assign bus.fwd_a_hit = hitA;
    assign bus.fwd_b_hit = hitB;
    assign bus.fwd_data  = rfWd_q;
`else
    assign hitA = 1'b0;
    assign hitB = 1'b0;
`endif

    wb_scoreboard #(
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en_i  (bus.rsv_en),
        .set_idx_i (bus.rsv_addr),
        .clr_en_i  (rfWerf_q),
        .clr_idx_i (wrIdx),
        .chk_a_i   (bus.chk_a),
        .chk_b_i   (bus.chk_b),
        .mask_a_i  (hitA),
        .mask_b_i  (hitB),
        .hazard_o  (bus.hazard)
    );

endmodule
